// File: rtl/board_writer_pkg.sv
// Shared constants, FSM state type and packed-slot helpers for the board RAM.
// A board RAM word holds four 2-bit template codes, slot 0 in the top bits.
package board_writer_pkg;

  localparam int BOARD_COLS    = 10;
  localparam int BOARD_ROWS    = 20;
  localparam int WORDS_PER_ROW = 3;
  localparam int ADDR_W        = 6;
  localparam int WORD_COUNT    = BOARD_ROWS * WORDS_PER_ROW;

  localparam logic [1:0] TEMPLATE_EMPTY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MOD,
    S_NEXT,
    S_CLR,
    S_DONE
  } state_e;

  // Slot s lives at bits [7-2s:6-2s], i.e. a left shift of 6-2s = 2*(3-s).
  function automatic logic [2:0] slot_shift(input logic [1:0] slot);
    return {~slot, 1'b0};
  endfunction

  function automatic logic [7:0] slot_insert(input logic [7:0] word,
                                             input logic [1:0] slot,
                                             input logic [1:0] code);
    logic [7:0] mask;
    mask = 8'h03 << slot_shift(slot);
    return (word & ~mask) | (8'(code) << slot_shift(slot));
  endfunction

  function automatic logic [1:0] slot_get(input logic [7:0] word,
                                          input logic [1:0] slot);
    return 2'(word >> slot_shift(slot));
  endfunction

endpackage

// File: rtl/board_writer_if.sv
// Command handshake plus board RAM write-port bundle for board_writer.
// master = game logic and RAM side, slave = the writer block.
interface board_writer_if;
  import board_writer_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [15:0]       cell_x;
  logic [19:0]       cell_y;
  logic [1:0]        cell_template;
  logic              busy;
  logic              done;
  logic              collision;
  logic              range_err;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_re;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  modport master (
    output cmd_valid, cmd_op, cell_x, cell_y, cell_template, ram_rdata,
    input  cmd_ready, busy, done, collision, range_err,
           ram_addr, ram_re, ram_we, ram_wdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cell_x, cell_y, cell_template, ram_rdata,
    output cmd_ready, busy, done, collision, range_err,
           ram_addr, ram_re, ram_we, ram_wdata
  );

endinterface

// File: rtl/board_writer_addr_calc.sv
// Maps a playfield cell (x, y) to its board RAM word address and 2-bit slot.
module board_writer_addr_calc
  import board_writer_pkg::*;
(
  input  logic [3:0]        x,
  input  logic [4:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        slot,
  output logic              in_range
);

  // Four slots per word, so x/4 is just the top two bits of x.
  assign addr     = ADDR_W'(y) * ADDR_W'(WORDS_PER_ROW) + ADDR_W'(x[3:2]);
  assign slot     = x[1:0];
  assign in_range = (x < 4'(BOARD_COLS)) && (y < 5'(BOARD_ROWS));

endmodule

// File: rtl/board_writer.sv
// Writes locked pieces into the packed board RAM by serial read-modify-write,
// and zero-fills the whole board on a clear command.
module board_writer
  import board_writer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  board_writer_if.slave bus
);

  state_e            state_q, state_d;
  logic [15:0]       x_q, x_d;
  logic [19:0]       y_q, y_d;
  logic [1:0]        tmpl_q, tmpl_d;
  logic [1:0]        k_q, k_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              coll_q, coll_d;
  logic              rerr_q, rerr_d;

  logic [3:0]        cell_x_a [4];
  logic [4:0]        cell_y_a [4];
  logic [ADDR_W-1:0] cur_addr;
  logic [1:0]        cur_slot;
  logic              cur_in_range;

  for (genvar gi = 0; gi < 4; gi++) begin : g_cell
    assign cell_x_a[gi] = x_q[4*gi +: 4];
    assign cell_y_a[gi] = y_q[5*gi +: 5];
  end

  board_writer_addr_calc u_addr_calc (
    .x        (cell_x_a[k_q]),
    .y        (cell_y_a[k_q]),
    .addr     (cur_addr),
    .slot     (cur_slot),
    .in_range (cur_in_range)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    tmpl_d  = tmpl_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    coll_d  = coll_q;
    rerr_d  = rerr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          x_d     = bus.cell_x;
          y_d     = bus.cell_y;
          tmpl_d  = bus.cell_template;
          k_d     = 2'd0;
          cnt_d   = '0;
          coll_d  = 1'b0;
          rerr_d  = 1'b0;
          state_d = bus.cmd_op ? S_CLR : S_RD;
        end
      end
      S_RD: begin
        if (cur_in_range) begin
          state_d = S_MOD;
        end else begin
          rerr_d  = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_MOD: begin
        if (slot_get(bus.ram_rdata, cur_slot) != TEMPLATE_EMPTY) coll_d = 1'b1;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (k_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = S_RD;
        end
      end
      S_CLR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(WORD_COUNT - 1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      tmpl_q  <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      coll_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tmpl_q  <= tmpl_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      coll_q  <= coll_d;
      rerr_q  <= rerr_d;
    end
  end

  // Outputs decode the state register; reset masks them so an interrupted
  // clear or piece stops touching RAM in the very cycle reset is raised.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.collision = 1'b0;
    bus.range_err = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_re    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = 8'h00;
    if (!reset) begin
      bus.cmd_ready = (state_q == S_IDLE);
      bus.busy      = (state_q != S_IDLE);
      bus.done      = (state_q == S_DONE);
      bus.collision = coll_q;
      bus.range_err = rerr_q;
      case (state_q)
        S_RD: begin
          if (cur_in_range) begin
            bus.ram_re   = 1'b1;
            bus.ram_addr = cur_addr;
          end
        end
        S_MOD: begin
          bus.ram_we    = 1'b1;
          bus.ram_addr  = cur_addr;
          bus.ram_wdata = slot_insert(bus.ram_rdata, cur_slot, tmpl_q);
        end
        S_CLR: begin
          bus.ram_we   = 1'b1;
          bus.ram_addr = cnt_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_writer.sv
// Directed bench for board_writer: a behavioural board RAM with registered
// read, hand-computed expected words, latencies and flags.
module tb_board_writer;
  import board_writer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  board_writer_if bw();

  board_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bw)
  );

  logic [7:0] mem [60];
  logic [5:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  int rd_cnt = 0;
  int acc_cnt = 0;
  int overlap_cnt = 0;
  int total = 0;
  int bad = 0;
  int wb, rb, lat, bcyc, seq_err, dones, acc0;

  always @(posedge clk) begin
    if (bw.ram_we) begin
      mem[bw.ram_addr] <= bw.ram_wdata;
      wr_addr_q.push_back(bw.ram_addr);
      wr_data_q.push_back(bw.ram_wdata);
    end
    if (bw.ram_re) begin
      bw.ram_rdata <= mem[bw.ram_addr];
      rd_cnt++;
    end
    if (bw.cmd_valid && bw.cmd_ready) acc_cnt++;
    if (bw.ram_we && bw.ram_re) overlap_cnt++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 60; i++) mem[i] = v;
  endtask

  // lat = working cycles between the accept cycle and the DONE cycle.
  task automatic send(input logic op, input logic [15:0] x, input logic [19:0] y,
                      input logic [1:0] t, output int l, output int bc);
    wb = wr_addr_q.size();
    rb = rd_cnt;
    bw.cmd_valid = 1'b1;
    bw.cmd_op = op;
    bw.cell_x = x;
    bw.cell_y = y;
    bw.cell_template = t;
    tick();
    bw.cmd_valid = 1'b0;
    l = -1;
    bc = 0;
    for (int i = 1; i <= 200; i++) begin
      if (bw.busy) bc++;
      if (bw.done) begin
        l = i - 1;
        break;
      end
      tick();
    end
    tick();
  endtask

  initial begin
    bw.cmd_valid = 1'b0;
    bw.cmd_op = 1'b0;
    bw.cell_x = '0;
    bw.cell_y = '0;
    bw.cell_template = '0;
    fill(8'h00);

    tick();
    chk("rst_ready", bw.cmd_ready, 0);
    chk("rst_busy", bw.busy, 0);
    chk("rst_done", bw.done, 0);
    chk("rst_we_re", {bw.ram_we, bw.ram_re}, 0);
    chk("rst_addr_wdata", {bw.ram_addr, bw.ram_wdata}, 0);
    chk("rst_flags", {bw.collision, bw.range_err}, 0);
    reset = 1'b0;
    tick();
    chk("idle_ready", bw.cmd_ready, 1);

    // Row 0 fully filled with template 11 in one word
    send(1'b0, 16'h3210, 20'h0, 2'b11, lat, bcyc);
    chk("p1_writes", wr_addr_q.size() - wb, 4);
    chk("p1_reads", rd_cnt - rb, 4);
    chk("p1_wd0", wr_data_q[wb], 8'hC0);
    chk("p1_wd1", wr_data_q[wb+1], 8'hF0);
    chk("p1_wd2", wr_data_q[wb+2], 8'hFC);
    chk("p1_wd3", wr_data_q[wb+3], 8'hFF);
    chk("p1_mem0", mem[0], 8'hFF);
    chk("p1_lat", lat, 12);
    chk("p1_flags", {bw.collision, bw.range_err}, 0);
    chk("p1_ready", bw.cmd_ready, 1);

    // Cell (5,1) lands on an occupied word, others on the last row
    mem[4] = 8'hFF;
    send(1'b0, 16'h8405, {5'd19, 5'd19, 5'd19, 5'd1}, 2'b01, lat, bcyc);
    chk("p2_mem4", mem[4], 8'hDF);
    chk("p2_mem57", mem[57], 8'h40);
    chk("p2_mem58", mem[58], 8'h40);
    chk("p2_mem59", mem[59], 8'h40);
    chk("p2_collision", bw.collision, 1);
    chk("p2_range_err", bw.range_err, 0);
    chk("p2_lat", lat, 12);

    // Cells (10,0) and (0,20) are off the board; (1,2),(2,2) share word 6
    send(1'b0, {4'd2, 4'd0, 4'd1, 4'd10}, {5'd2, 5'd20, 5'd2, 5'd0}, 2'b10, lat, bcyc);
    chk("p3_writes", wr_addr_q.size() - wb, 2);
    chk("p3_reads", rd_cnt - rb, 2);
    chk("p3_mem6", mem[6], 8'h28);
    chk("p3_range_err", bw.range_err, 1);
    chk("p3_collision", bw.collision, 0);
    chk("p3_lat", lat, 10);

    // Full clear over a board of 8'hAA
    fill(8'hAA);
    send(1'b1, 16'h0, 20'h0, 2'b00, lat, bcyc);
    chk("clr_writes", wr_addr_q.size() - wb, 60);
    seq_err = 0;
    for (int i = 0; i < 60; i++) begin
      if (wr_addr_q[wb+i] !== 6'(i) || wr_data_q[wb+i] !== 8'h00) seq_err++;
    end
    chk("clr_seq", seq_err, 0);
    chk("clr_busy_cycles", bcyc, 61);
    chk("clr_lat", lat, 60);
    chk("clr_mem0_59", {mem[0], mem[59]}, 16'h0000);
    chk("clr_flags", {bw.collision, bw.range_err}, 0);
    chk("clr_ready", bw.cmd_ready, 1);

    // Reset during the 20th clear cycle (address 19)
    fill(8'hAA);
    wb = wr_addr_q.size();
    bw.cmd_valid = 1'b1;
    bw.cmd_op = 1'b1;
    tick();
    bw.cmd_valid = 1'b0;
    for (int i = 2; i <= 20; i++) tick();
    chk("rclr_addr19", {bw.ram_we, bw.ram_addr}, {1'b1, 6'd19});
    reset = 1'b1;
    tick();
    chk("rclr_we", bw.ram_we, 0);
    chk("rclr_busy", bw.busy, 0);
    reset = 1'b0;
    tick();
    chk("rclr_ready", bw.cmd_ready, 1);
    chk("rclr_writes", wr_addr_q.size() - wb, 19);
    chk("rclr_mem18", mem[18], 8'h00);
    chk("rclr_mem19", mem[19], 8'hAA);
    chk("rclr_mem59", mem[59], 8'hAA);
    send(1'b0, 16'h3210, {4{5'd5}}, 2'b01, lat, bcyc);
    chk("rclr_piece_mem15", mem[15], 8'h55);
    chk("rclr_piece_lat", lat, 12);

    // cmd_valid held across two commands; inputs change mid-command
    mem[30] = 8'h00;
    mem[33] = 8'h00;
    acc0 = acc_cnt;
    bw.cmd_valid = 1'b1;
    bw.cmd_op = 1'b0;
    bw.cell_x = 16'h3210;
    bw.cell_y = {4{5'd10}};
    bw.cell_template = 2'b01;
    tick();
    tick();
    tick();
    bw.cell_y = {4{5'd11}};
    bw.cell_template = 2'b10;
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      if (bw.done) dones++;
      if (dones == 2) break;
      tick();
    end
    bw.cmd_valid = 1'b0;
    tick();
    tick();
    chk("hold_dones", dones, 2);
    chk("hold_accepts", acc_cnt - acc0, 2);
    chk("hold_mem30", mem[30], 8'h55);
    chk("hold_mem33", mem[33], 8'hAA);
    chk("we_re_overlap", overlap_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_writer.md
Name: board_writer

Overview:
- Write-side counterpart of the board block-template store. The pixel path reads packed 2-bit template codes out of board RAM words; this block puts them there.
- Accepts "lock piece" commands (4 cells, one template) and "clear board" commands from game logic.
- Lock-piece performs a per-cell read-modify-write on the 8-bit packed board RAM. Clear-board zero-fills the RAM.
- Sits between the game-logic FSM and the board RAM write port.

Parameters:
- COLS, 10, playfield columns
- ROWS, 20, playfield rows
- WORDS_PER_ROW, 3, RAM words per row (4 slots/word, slots 10-11 of each row unused)
- ADDR_W, 6, RAM address width (ROWS*WORDS_PER_ROW = 60 words)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
- cmd_op  in  1  0 = lock piece, 1 = clear board
- cell_x  in  16  four 4-bit column indices, cell k at [4k+3:4k]
- cell_y  in  20  four 5-bit row indices, cell k at [5k+4:5k]
- cell_template  in  2  template code written to all four cells
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when a command completes
- collision  out  1  valid with done; any target slot was non-zero before the write
- range_err  out  1  valid with done; any cell had x >= COLS or y >= ROWS
- ram_addr  out  ADDR_W  board RAM word address
- ram_re  out  1  read strobe
- ram_we  out  1  write strobe
- ram_wdata  out  8  write data
- ram_rdata  in  8  read data, valid exactly 1 cycle after ram_re

Behaviour:
- Reset values: cmd_ready=0 during the reset cycle, then 1 in IDLE.
- Reset values: busy=0, done=0, collision=0, range_err=0, ram_re=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Latched at accept: cmd_op, cell_x, cell_y, cell_template. Later changes on these inputs are ignored until the next accept.
- Packing:
  - word address = y*WORDS_PER_ROW + x/4
  - slot s = x%4; slot 0 is leftmost and occupies bits [7:6]; slot 3 occupies bits [1:0]
  - Slot s occupies bits [7-2s:6-2s]
- States: IDLE, RD, MOD, NEXT, CLR, DONE.
- IDLE:
  - On accept with op=0: cell index k=0, clear the collision and range_err accumulators, go to RD.
  - On accept with op=1: address counter=0, go to CLR.
- RD:
  - If cell k is out of range: set range_err accumulator, no RAM access, go to NEXT.
  - Otherwise: drive ram_addr, ram_re=1, go to MOD.
- MOD:
  - ram_rdata is valid in this state.
  - Drive ram_we=1 at the same address.
  - ram_wdata = ram_rdata with slot s replaced by cell_template.
  - If the old slot value != 2'b00, set the collision accumulator. Go to NEXT.
- NEXT: if k==3, go to DONE; else k++ and go to RD.
- RMW is strictly serial, so two cells in the same word both land correctly: the second read sees the first write.
- Timing: 2 cycles per in-range cell, 1 per out-of-range cell, plus NEXT cycles. A full in-range piece = 12 cycles from accept to DONE.
- Template 2'b00 is written like any other code (used for erase).
- CLR:
  - ram_we=1, ram_wdata=8'h00, ram_addr=counter.
  - Counter increments each cycle; after address 59, go to DONE.
  - Exactly 60 writes.
  - collision=0 and range_err=0 for clear.
- DONE: done=1 for one cycle, collision/range_err drive the accumulators, return to IDLE. Flags hold their value until the next accept.
- A cmd_valid that arrives while busy is not accepted. The requester holds it until cmd_ready.
- Reset mid-operation: next cycle is IDLE. No further ram_we/ram_re; a partially written piece or clear is left as-is.
- ram_we and ram_re are never high in the same cycle.

Decomposition:
- Shared package (alongside the existing template package):
  - state enum
  - BOARD_COLS, BOARD_ROWS, WORDS_PER_ROW
  - template code constant for empty (2'b00)
  - slot_insert function (word, slot, code) -> word, reused by the line-clear logic
- One natural sub-module: board_addr_calc (x, y -> word address, slot, in_range), combinational.

Test Plan:
- Lock piece, cells (0,0),(1,0),(2,0),(3,0), template 11, bench RAM all zero:
  - four RMWs at addr 0, final word 8'hFF
  - done at cycle 12 after accept, collision=0, range_err=0
- Single occupied target: cell (5,1) template 01, RAM[4]=8'hFF, other cells (0,19),(4,19),(8,19):
  - RAM[4] becomes 8'hDF; RAM[57]=8'h40, RAM[58]=8'h40, RAM[59]=8'h40
  - collision=1
- Out-of-range cells (10,0) and (0,20) with two valid cells:
  - no RAM access for the bad cells, range_err=1
  - done at cycle 10
- Clear board with RAM preloaded 8'hAA:
  - 60 consecutive writes of 8'h00, addresses 0..59
  - busy high 61 cycles, done pulse, cmd_ready back to 1
- Reset asserted on the 20th CLR cycle:
  - ram_we low the next cycle, busy=0, RAM[19..59] retain 8'hAA
  - a following piece command is accepted normally
- cmd_valid held high through a command:
  - exactly one command accepted per IDLE visit
  - ram_we/ram_re never high in the same cycle (assertion)
